seq_mul_div: RTL and testbench

SEQ_MUL_DIV -- requirements
Module: seq_mul_div

---
 rtl/seq_mul_div.sv | 145 ++++++++++++++
 tb/tb_seq_mul_div.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_div.sv
// Sequential unsigned multiplier / restoring divider.
// One iteration per clock; both operations share one 2*WIDTH+1 bit accumulator.
module seq_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [AW-1:0]    acc_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] operand_reg;
    logic             op_reg;
    logic             dbz_reg;

    logic             accept;
    logic             last_iter;
    logic             div_zero;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_upper;
    logic [AW-1:0]    mul_step;
    logic [AW-1:0]    div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [AW-1:0]    div_step;

    assign accept    = (state_reg != RUN) && Start;
    assign last_iter = (count_reg == CW'(WIDTH - 1));
    assign div_zero  = op_reg && (operand_reg == '0);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (div_zero || last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = Start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_reg)
            RUN:     Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    // Multiply step: conditionally add multiplicand into the upper half, then shift right.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, operand_reg};
        mul_upper = acc_reg[0] ? mul_sum : acc_reg[AW-1:WIDTH];
        mul_step  = {mul_upper, acc_reg[WIDTH-1:0]} >> 1;
    end

    // Restoring divide step: shift {rem, quotient} left, keep trial difference if non-negative.
    always_comb begin
        div_shift = {acc_reg[AW-2:0], 1'b0};
        div_diff  = {1'b0, div_shift[AW-1:WIDTH]} - {2'b00, operand_reg};
        if (div_diff[WIDTH+1]) begin
            div_step = div_shift;
        end else begin
            div_step = {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
        end
    end

    // Datapath: operand latch, accumulator, iteration counter, divide-by-zero flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc_reg     <= '0;
            count_reg   <= '0;
            operand_reg <= '0;
            op_reg      <= 1'b0;
            dbz_reg     <= 1'b0;
        end else if (accept) begin
            op_reg      <= Op;
            operand_reg <= Op ? B : A;
            acc_reg     <= {{(WIDTH + 1){1'b0}}, (Op ? A : B)};
            count_reg   <= '0;
            dbz_reg     <= 1'b0;
        end else if (state_reg == RUN) begin
            if (div_zero) begin
                // Dividend moves to the high word, quotient saturates to all ones.
                acc_reg <= {1'b0, acc_reg[WIDTH-1:0], {WIDTH{1'b1}}};
                dbz_reg <= 1'b1;
            end else begin
                acc_reg   <= op_reg ? div_step : mul_step;
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign Result    = acc_reg[WIDTH-1:0];
    assign ResultHi  = acc_reg[2*WIDTH-1:WIDTH];
    assign DivByZero = dbz_reg;

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed bench for seq_mul_div: driver pushes expected results into a queue,
// an independent monitor pops and compares on every Done pulse.
module tb_seq_mul_div;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Result;
    logic [31:0] ResultHi;
    logic        Busy;
    logic        Done;
    logic        DivByZero;

    seq_mul_div #(.WIDTH(32)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Result    (Result),
        .ResultHi  (ResultHi),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        dbz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   errors   = 0;
    int   checks   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples just after each rising edge
    always @(posedge Clock) begin
        #1;
        if (Reset) begin
            busy_cnt = 0;
        end else begin
            if (Busy) busy_cnt++;
            if (Done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result",    {32'd0, Result},   {32'd0, e.r});
                    chk("result_hi", {32'd0, ResultHi}, {32'd0, e.h});
                    chk("div_by_zero", {63'd0, DivByZero}, {63'd0, e.dbz});
                    chk("latency",   64'(cyc - e.acc_cyc), 64'(e.lat));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                    chk("busy_low_on_done", {63'd0, Busy}, 64'd0);
                    $display("txn done: result=%08h hi=%08h dbz=%0b latency=%0d",
                             Result, ResultHi, DivByZero, cyc - e.acc_cyc);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drives Start at the current falling edge; the next rising edge accepts it.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] eh, input logic edbz);
        exp_t e;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        e.r = er; e.h = eh; e.dbz = edbz;
        e.acc_cyc = cyc + 1;
        e.lat = (op && b == 32'd0) ? 1 : 32;
        q.push_back(e);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!Done && n < bound) begin
            @(negedge Clock);
            n++;
        end
        if (!Done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got Done=0 expected Done=1 within %0d cycles", bound);
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [31:0] eh, input logic edbz);
        @(negedge Clock);
        issue(op, a, b, er, eh, edbz);
        @(negedge Clock);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        Op    = ~op;
        wait_done(100);
        @(negedge Clock);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_result"},    {32'd0, Result},   64'd0);
        chk({tag, "_result_hi"}, {32'd0, ResultHi}, 64'd0);
        chk({tag, "_busy"},      {63'd0, Busy},     64'd0);
        chk({tag, "_done"},      {63'd0, Done},     64'd0);
        chk({tag, "_dbz"},       {63'd0, DivByZero}, 64'd0);
    endtask

    initial begin
        // Reset with Start held high: reset must win
        Reset = 1'b1;
        Start = 1'b1;
        Op    = 1'b0;
        A     = 32'd7;
        B     = 32'd6;
        repeat (3) @(negedge Clock);
        check_cleared("reset");
        Reset = 1'b0;
        Start = 1'b0;

        run_op(1'b0, 32'd7,          32'd6,          32'd42,         32'd0,          1'b0);
        run_op(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE,   1'b0);
        run_op(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        run_op(1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);

        // Results and DivByZero hold while idle
        repeat (3) @(negedge Clock);
        chk("hold_dbz",    {63'd0, DivByZero}, 64'd1);
        chk("hold_result", {32'd0, Result},    64'h00000000FFFFFFFF);
        chk("hold_hi",     {32'd0, ResultHi},  64'd5);

        run_op(1'b0, 32'h12345678,   32'h00000010,   32'h23456780,   32'h00000001,   1'b0);
        run_op(1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0);
        run_op(1'b1, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0);
        run_op(1'b1, 32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0);
        run_op(1'b0, 32'h00010000,   32'h00010000,   32'd0,          32'd1,          1'b0);
        run_op(1'b0, 32'h80000000,   32'd2,          32'd0,          32'd1,          1'b0);

        // Start pulse during RUN is ignored
        @(negedge Clock);
        issue(1'b0, 32'd1000, 32'd3000, 32'h002DC6C0, 32'd0, 1'b0);
        @(negedge Clock);
        Start = 1'b0;
        repeat (9) @(negedge Clock);
        Start = 1'b1; Op = 1'b1; A = 32'd9; B = 32'd9;
        @(negedge Clock);
        Start = 1'b0;
        wait_done(100);
        @(negedge Clock);

        // Back-to-back: Start held through Done
        @(negedge Clock);
        issue(1'b1, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
        @(negedge Clock);
        Op = 1'b0; A = 32'hDEADBEEF; B = 32'd2;
        wait_done(100);
        issue(1'b0, 32'hDEADBEEF, 32'd2, 32'hBD5B7DDE, 32'd1, 1'b0);
        @(negedge Clock);
        Start = 1'b0;
        chk("b2b_busy", {63'd0, Busy}, 64'd1);
        wait_done(100);
        @(negedge Clock);

        // Reset mid-operation aborts without a Done pulse
        @(negedge Clock);
        issue(1'b0, 32'd5, 32'd5, 32'd25, 32'd0, 1'b0);
        @(negedge Clock);
        Start = 1'b0;
        repeat (14) @(negedge Clock);
        Reset = 1'b1;
        q.delete();
        @(negedge Clock);
        check_cleared("abort");
        Reset = 1'b0;
        repeat (40) @(negedge Clock);
        run_op(1'b0, 32'd5, 32'd5, 32'd25, 32'd0, 1'b0);

        repeat (2) @(negedge Clock);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
